// File: rtl/core_pkg.sv
// Shared definitions for the core: sequencer states, opcode/subop encodings,
// ALU operation codes and the decoded control word.
// Build option: CORE_HALT_EN adds the terminal HALT state and the decoder's
// halt request for the IDLE opcode.
package core_pkg;

  // Sequencer states; HALT exists only when the halt feature is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
`ifdef CORE_HALT_EN
    ,
    ST_HALT   = 3'd5
`endif
  } state_t;

  // Primary opcodes, taken from ir[30:25].
  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ALU  = 6'b100000;
  localparam logic [5:0] OP_MOVI = 6'b100010;
  localparam logic [5:0] OP_ADDI = 6'b101000;
  localparam logic [5:0] OP_XORI = 6'b101011;
  localparam logic [5:0] OP_ORI  = 6'b101100;
  localparam logic [5:0] OP_IDLE = 6'b111111;

  // Register-form ALU subops, taken from ir[4:0] when the opcode is OP_ALU.
  localparam logic [4:0] SUB_ADD   = 5'b00000;
  localparam logic [4:0] SUB_SUB   = 5'b00001;
  localparam logic [4:0] SUB_AND   = 5'b00010;
  localparam logic [4:0] SUB_XOR   = 5'b00011;
  localparam logic [4:0] SUB_OR    = 5'b00100;
  localparam logic [4:0] SUB_SLLI  = 5'b01000;
  localparam logic [4:0] SUB_SRLI  = 5'b01001;
  localparam logic [4:0] SUB_ROTRI = 5'b01011;

  // Operation codes presented to the datapath ALU.
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_ROTR = 4'd8,
    ALU_MOV  = 4'd9
  } alu_op_t;

  // Decoded control word for one instruction; the sequencer gates it by state.
  typedef struct packed {
    alu_op_t alu_op;
    logic    imm_sel;
    logic    rf_read;
    logic    rf_write;
    logic    illegal;
`ifdef CORE_HALT_EN
    logic    halt;
`endif
  } ctrl_t;

  // Control word for an ALU op that reads and writes the register file.
  function automatic ctrl_t alu_ctrl(input alu_op_t op, input logic imm);
    ctrl_t c;
    c          = '0;
    c.alu_op   = op;
    c.imm_sel  = imm;
    c.rf_read  = 1'b1;
    c.rf_write = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/core_decoder.sv
// Combinational opcode/subop to control-word mapping.
// Undecoded opcodes or subops produce a non-writing control word with the
// illegal bit set. With CORE_HALT_EN the IDLE opcode raises halt; without it
// IDLE decodes exactly like NOP.
module core_decoder
  import core_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] subop,
  output ctrl_t      ctrl
);

  // Map the instruction fields onto the control word, defaulting to NOP.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_NOP;
    case (opcode)
      OP_ALU: begin
        case (subop)
          SUB_ADD:   ctrl = alu_ctrl(ALU_ADD,  1'b0);
          SUB_SUB:   ctrl = alu_ctrl(ALU_SUB,  1'b0);
          SUB_AND:   ctrl = alu_ctrl(ALU_AND,  1'b0);
          SUB_XOR:   ctrl = alu_ctrl(ALU_XOR,  1'b0);
          SUB_OR:    ctrl = alu_ctrl(ALU_OR,   1'b0);
          SUB_SLLI:  ctrl = alu_ctrl(ALU_SLL,  1'b0);
          SUB_SRLI:  ctrl = alu_ctrl(ALU_SRL,  1'b0);
          SUB_ROTRI: ctrl = alu_ctrl(ALU_ROTR, 1'b0);
          default:   ctrl.illegal = 1'b1;
        endcase
      end
      OP_MOVI: ctrl = alu_ctrl(ALU_MOV, 1'b1);
      OP_ADDI: ctrl = alu_ctrl(ALU_ADD, 1'b1);
      OP_XORI: ctrl = alu_ctrl(ALU_XOR, 1'b1);
      OP_ORI:  ctrl = alu_ctrl(ALU_OR,  1'b1);
      OP_NOP:  ctrl.illegal = 1'b0;
      OP_IDLE: begin
`ifdef CORE_HALT_EN
        ctrl.halt = 1'b1;
`else
        ctrl.illegal = 1'b0;
`endif
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB, four cycles
// per instruction back to back while run stays high.
// Instruction memory protocol: IM_read/IM_enable are high for the single FETCH
// cycle with PC as the address; the memory returns the word on instruction in
// the following (DECODE) cycle, and it is captured into ir on the
// DECODE->EXEC edge. There is no stall path: the memory must answer in one cycle.
// run is only sampled in IDLE and WB, so an instruction in flight always
// finishes its write-back.
// Build option: CORE_HALT_EN makes the IDLE opcode park the core in HALT
// (halted=1) until reset; otherwise IDLE executes as a NOP and halted is 0.
module core_sequencer
  import core_pkg::*;
#(
  parameter int DataSize = 32,
  parameter int MemSize  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [DataSize-1:0] instruction,
  output logic [MemSize-1:0]  PC,
  output logic                IM_read,
  output logic                IM_write,
  output logic                IM_enable,
  output logic                rf_read,
  output logic                rf_write,
  output alu_op_t             alu_op,
  output logic                imm_sel,
  output logic [DataSize-1:0] ir,
  output logic                illegal,
  output logic                halted,
  output state_t              fsm_state
);

  localparam logic [MemSize-1:0] PcOne = {{(MemSize-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  // Decode is purely a function of the latched instruction register.
  core_decoder u_decoder (
    .opcode (ir[30:25]),
    .subop  (ir[4:0]),
    .ctrl   (ctrl)
  );

  assign fsm_state = state;
  assign IM_write  = 1'b0;

  // State register; reset drops any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PC advances once per instruction, on the edge leaving WB (wraps naturally).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC <= '0;
    end else if (state == ST_WB) begin
      PC <= PC + PcOne;
    end
  end

  // Instruction register captures the memory word returned during DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= '0;
    end else if (state == ST_DECODE) begin
      ir <= instruction;
    end
  end

  // Sticky flag for undecoded instructions, raised as EXEC completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
    end else if ((state == ST_EXEC) && ctrl.illegal) begin
      illegal <= 1'b1;
    end
  end

  // Next-state selection and per-state strobes, all inactive by default.
  always_comb begin
    state_next = state;
    IM_enable  = 1'b0;
    IM_read    = 1'b0;
    rf_read    = 1'b0;
    rf_write   = 1'b0;
    alu_op     = ALU_NOP;
    imm_sel    = 1'b0;
    halted     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        IM_enable  = 1'b1;
        IM_read    = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        rf_read    = ctrl.rf_read;
        alu_op     = ctrl.alu_op;
        imm_sel    = ctrl.imm_sel;
        state_next = ST_WB;
      end
      ST_WB: begin
        rf_write = ctrl.rf_write;
        alu_op   = ctrl.alu_op;
        imm_sel  = ctrl.imm_sel;
`ifdef CORE_HALT_EN
        if (ctrl.halt) begin
          state_next = ST_HALT;
        end else if (run) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_IDLE;
        end
`else
        if (run) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_IDLE;
        end
`endif
      end
`ifdef CORE_HALT_EN
      ST_HALT: begin
        halted     = 1'b1;
        state_next = ST_HALT;
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer.
// The reference is instruction-level: each instruction occupies four cycles
// (fetch, decode, execute, write-back), its effect comes from opcode tables,
// and write-back control words go through an expected queue.
// Honours CORE_HALT_EN for the IDLE-opcode scenario.
module tb_core_sequencer;
  import core_pkg::*;

  localparam int DW    = 32;
  localparam int MW    = 10;
  localparam int DEPTH = 1 << MW;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [DW-1:0] instruction = '0;
  logic [MW-1:0] PC;
  logic          IM_read, IM_write, IM_enable, rf_read, rf_write;
  alu_op_t       alu_op;
  logic          imm_sel, illegal, halted;
  logic [DW-1:0] ir;
  state_t        fsm_state;

  always #5 clk = ~clk;

  core_sequencer #(.DataSize(DW), .MemSize(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .PC          (PC),
    .IM_read     (IM_read),
    .IM_write    (IM_write),
    .IM_enable   (IM_enable),
    .rf_read     (rf_read),
    .rf_write    (rf_write),
    .alu_op      (alu_op),
    .imm_sel     (imm_sel),
    .ir          (ir),
    .illegal     (illegal),
    .halted      (halted),
    .fsm_state   (fsm_state)
  );

  // ---------------------------------------------------------------- model state
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          model_pc = 0;
  bit          model_illegal = 1'b0;
  bit          model_halted  = 1'b0;
  logic [DW-1:0] imem [DEPTH];
  logic [4:0]  exp_q [$];
  alu_op_t     reg_tab [int];
  alu_op_t     imm_tab [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: the memory answers a fetch seen before the edge; otherwise the
  // bus carries junk so a mistimed ir capture is visible.
  task automatic tick();
    bit            f = IM_read;
    logic [MW-1:0] a = PC;
    @(posedge clk);
    #1;
    cyc++;
    instruction = f ? imem[a] : $urandom;
  endtask

  // Expected effect of one instruction from the opcode tables.
  function automatic void ref_decode(input logic [DW-1:0] ins, output bit wr,
                                     output alu_op_t op, output bit imm,
                                     output bit ill, output bit idl);
    int opc = int'(ins[30:25]);
    int sub = int'(ins[4:0]);
    wr = 1'b0; op = ALU_NOP; imm = 1'b0; ill = 1'b0; idl = 1'b0;
    if (opc == 32) begin
      if (reg_tab.exists(sub)) begin
        wr = 1'b1; op = reg_tab[sub];
      end else begin
        ill = 1'b1;
      end
    end else if (imm_tab.exists(opc)) begin
      wr = 1'b1; op = imm_tab[opc]; imm = 1'b1;
    end else if (opc == 63) begin
      idl = 1'b1;
    end else if (opc != 0) begin
      ill = 1'b1;
    end
  endfunction

  function automatic logic [DW-1:0] mk(input logic [5:0] opc, input logic [4:0] sub);
    logic [DW-1:0] w = $urandom;
    w[30:25] = opc;
    w[4:0]   = sub;
    return w;
  endfunction

  // Random instruction mix: legal ALU/immediate ops, NOPs and undecoded ones.
  function automatic logic [DW-1:0] gen_instr();
    logic [4:0] subs [8] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h09, 5'h0b};
    logic [5:0] imms [4] = '{6'b100010, 6'b101000, 6'b101011, 6'b101100};
    logic [5:0] opc;
    int         k = int'($urandom_range(0, 9));
    if (k <= 3) return mk(6'b100000, subs[$urandom_range(0, 7)]);
    if (k <= 6) return mk(imms[$urandom_range(0, 3)], 5'($urandom));
    if (k == 7) return mk(6'b000000, 5'($urandom));
    if (k == 8) begin
      do opc = 6'($urandom);
      while (opc == 6'd0 || opc == 6'd32 || opc == 6'd34 || opc == 6'd40 ||
             opc == 6'd43 || opc == 6'd44 || opc == 6'd63);
      return mk(opc, 5'($urandom));
    end
    return mk(6'b100000, 5'($urandom));
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic check_reset_vals(input string w);
    check({w, "_pc"},       64'(PC),       '0);
    check({w, "_ir"},       64'(ir),       '0);
    check({w, "_illegal"},  64'(illegal),  '0);
    check({w, "_halted"},   64'(halted),   '0);
    check({w, "_strobes"},  64'({IM_read, IM_write, IM_enable, rf_read, rf_write}), '0);
    check({w, "_alu_op"},   64'(alu_op),   64'(ALU_NOP));
    check({w, "_imm_sel"},  64'(imm_sel),  '0);
    check({w, "_state"},    64'(fsm_state), 64'(ST_IDLE));
  endtask

  // Runs one instruction starting in its fetch cycle; run is randomized where
  // it must be ignored and set to run_at_wb for the write-back decision.
  task automatic do_instr(input bit run_at_wb, output int fcyc);
    int            pc  = model_pc;
    logic [DW-1:0] ins = imem[pc];
    bit            wr, imm, ill, idl;
    alu_op_t       op;
    logic [4:0]    got;
    ref_decode(ins, wr, op, imm, ill, idl);
    fcyc = cyc;
    check("fetch_im_read",   64'(IM_read),   64'd1);
    check("fetch_im_enable", 64'(IM_enable), 64'd1);
    check("fetch_im_write",  64'(IM_write),  64'd0);
    check("fetch_pc",        64'(PC),        64'(pc));
    check("fetch_rf",        64'({rf_read, rf_write}), 64'd0);
    check("fetch_illegal",   64'(illegal),   64'(model_illegal));
    check("fetch_halted",    64'(halted),    64'(model_halted));
    run = 1'($urandom_range(0, 1));
    tick();
    check("decode_im",     64'({IM_read, IM_enable, IM_write}), 64'd0);
    check("decode_rf",     64'({rf_read, rf_write}), 64'd0);
    check("decode_alu_op", 64'(alu_op), 64'(ALU_NOP));
    run = run_at_wb ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    check("exec_ir",       64'(ir),       64'(ins));
    check("exec_im_read",  64'(IM_read),  64'd0);
    check("exec_rf_read",  64'(rf_read),  64'(wr));
    check("exec_rf_write", 64'(rf_write), 64'd0);
    check("exec_alu_op",   64'(alu_op),   64'(op));
    check("exec_imm_sel",  64'(imm_sel),  64'(imm));
    if (wr) exp_q.push_back({op, imm});
    tick();
    model_illegal = model_illegal | ill;
    check("wb_rf_write", 64'(rf_write), 64'(wr));
    check("wb_rf_read",  64'(rf_read),  64'd0);
    check("wb_alu_op",   64'(alu_op),   64'(op));
    check("wb_imm_sel",  64'(imm_sel),  64'(imm));
    check("wb_pc",       64'(PC),       64'(pc));
    check("wb_illegal",  64'(illegal),  64'(model_illegal));
    if (rf_write) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected_write", 64'd1, 64'd0);
      end else begin
        got = exp_q.pop_front();
        check("wb_write_ctrl", 64'({alu_op, imm_sel}), 64'(got));
      end
    end
    run = run_at_wb;
    tick();
    model_pc = (pc + 1) % DEPTH;
`ifdef CORE_HALT_EN
    if (idl) model_halted = 1'b1;
`endif
    check("next_pc", 64'(PC), 64'(model_pc));
  endtask

  // Sits in IDLE for n cycles, then raises run and steps into the next fetch.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_im_read", 64'(IM_read),  64'd0);
      check("idle_rf",      64'({rf_read, rf_write}), 64'd0);
      check("idle_pc",      64'(PC),       64'(model_pc));
      check("idle_state",   64'(fsm_state), 64'(ST_IDLE));
      tick();
    end
    run = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------- main flow
  initial begin
    int fc;
    bit rw;
    reg_tab[0] = ALU_ADD; reg_tab[1] = ALU_SUB; reg_tab[2] = ALU_AND; reg_tab[3] = ALU_XOR;
    reg_tab[4] = ALU_OR;  reg_tab[8] = ALU_SLL; reg_tab[9] = ALU_SRL; reg_tab[11] = ALU_ROTR;
    imm_tab[34] = ALU_MOV; imm_tab[40] = ALU_ADD; imm_tab[43] = ALU_XOR; imm_tab[44] = ALU_OR;
    for (int i = 0; i < DEPTH; i++) imem[i] = gen_instr();
    imem[0] = mk(6'b100010, 5'($urandom));
    imem[1] = mk(6'b100000, 5'b00000);
    imem[2] = mk(6'b100000, 5'b00001);
    imem[3] = mk(6'b010101, 5'($urandom));

    // Asynchronous reset, checked before any clock edge has occurred.
    #1 reset = 1'b0;
    #1 check_reset_vals("rst_async");
    @(posedge clk); @(posedge clk); #1;
    check_reset_vals("rst_held");
    reset = 1'b1;
    run   = 1'b1;
    cyc   = 0;
    check("release_idle", 64'(IM_read), 64'd0);
    tick();

    // MOVI, ADD, SUB, then an undecoded opcode; fetches at cycles 1, 5, 9.
    for (int k = 0; k < 4; k++) begin
      do_instr(1'b1, fc);
      if (k < 3) check("fetch_cycle", 64'(fc), 64'(1 + 4 * k));
    end
    check("illegal_sticky", 64'(illegal), 64'd1);

    // run dropped during EXEC: write-back completes, then IDLE at PC+1.
    do_instr(1'b0, fc);
    idle_gap(int'($urandom_range(1, 3)));

    // Long random program; wraps PC through 1023 -> 0.
    for (int i = 0; i < 1040; i++) begin
      rw = ($urandom_range(0, 15) != 0);
      if (model_pc == DEPTH - 1) rw = 1'b1;
      do_instr(rw, fc);
      if (!rw) idle_gap(int'($urandom_range(1, 3)));
    end

    // Reset asserted mid-instruction (DECODE of a writing op).
    imem[model_pc] = mk(6'b100000, 5'b00000);
    tick();
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_decode");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_write", 64'(rf_write), 64'd0);
    end
    check("exp_q_after_reset", 64'(exp_q.size()), 64'd0);

    // IDLE opcode behaviour.
    model_pc = 0; model_illegal = 1'b0; model_halted = 1'b0;
    imem[0] = mk(6'b100010, 5'($urandom));
    imem[1] = mk(6'b111111, 5'($urandom));
    imem[2] = mk(6'b100000, 5'b00010);
    imem[3] = mk(6'b101011, 5'($urandom));
    reset = 1'b1;
    run   = 1'b1;
    tick();
    do_instr(1'b1, fc);
    do_instr(1'b1, fc);
`ifdef CORE_HALT_EN
    for (int i = 0; i < 20; i++) begin
      check("halt_halted",  64'(halted),  64'd1);
      check("halt_im_read", 64'(IM_read), 64'd0);
      check("halt_rf",      64'({rf_read, rf_write}), 64'd0);
      check("halt_pc",      64'(PC),      64'd2);
      tick();
    end
`else
    check("no_halt_halted", 64'(halted), 64'd0);
    do_instr(1'b1, fc);
    do_instr(1'b1, fc);
`endif

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
